char_tx_buffer: RTL and testbench

//  Upstream feeder for the DPI character sink (char/strobe consumer). Accepts bytes

---
 rtl/char_tx_buffer.sv | 129 ++++++++++++
 tb/tb_char_tx_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/char_tx_buffer.sv
// char_tx_buffer: byte FIFO that replays its contents as char/strobe pulses.
// Each byte is held on char with strobe high for STROBE_CYCLES, followed by
// GAP_CYCLES of strobe low and one IDLE cycle, so the sink sees exactly one
// rising strobe per byte.
module char_tx_buffer #(
    parameter int DEPTH         = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [7:0]               char,
    output logic                     strobe,
    output logic                     busy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CMAX  = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      level_q;
    logic             overflow_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;
    logic             strobe_q, strobe_d;
    logic             push, drop, pop;

    // wr_ready comes straight from the occupancy register, so a write on the
    // same edge as a pop from a full FIFO is still rejected.
    assign wr_ready = (level_q != (AW+1)'(DEPTH));
    assign push     = wr_en && wr_ready;
    assign drop     = wr_en && !wr_ready;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign char     = char_q;
    assign strobe   = strobe_q;
    assign busy     = (state_q != IDLE) || (level_q != '0);

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overflow flag; a dropped write beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (clr_overflow) overflow_q <= 1'b0;
    end

    // Pulse FSM state register, including the registered char/strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            char_q   <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            strobe_q <= strobe_d;
        end
    end

    // Pulse FSM next state: pop on IDLE, hold strobe, then hold the gap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        char_d   = char_q;
        strobe_d = strobe_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    char_d   = mem[rptr];
                    strobe_d = 1'b1;
                    cnt_d    = CNT_W'(STROBE_CYCLES - 1);
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    strobe_d = 1'b0;
                    cnt_d    = CNT_W'(GAP_CYCLES - 1);
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d  = IDLE;
                strobe_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_char_tx_buffer.sv
// Directed bench for char_tx_buffer: per-cycle vector table for a single byte,
// plus hand-written sequences for overflow, back-to-back spacing and reset.
module tb_char_tx_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, clr_overflow;
    logic [7:0] wr_data;
    logic       wr_ready, overflow, strobe, busy;
    logic [4:0] level;
    logic [7:0] char;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // sink-side capture of every rising strobe
    logic       prev_strobe;
    logic [7:0] cap_ch[$];
    int         cap_cyc[$];

    char_tx_buffer #(.DEPTH(16), .STROBE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .level(level), .overflow(overflow),
        .clr_overflow(clr_overflow), .char(char), .strobe(strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) prev_strobe <= 1'b0;
        else begin
            if (strobe && !prev_strobe) begin
                cap_ch.push_back(char);
                cap_cyc.push_back(cyc);
            end
            prev_strobe <= strobe;
        end
    end

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       exp_strobe;
        logic [7:0] exp_char;
        logic       exp_busy;
        logic [4:0] exp_level;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one active edge, then settle to the following negedge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) step();
        chk("drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        logic [7:0] exp_list[$];

        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
        prev_strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {char, strobe, overflow, level, wr_ready, busy},
            {8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0});
        reset = 1'b0;
        step();

        // ---- single byte 0x41: cycle-by-cycle table ----
        vecs[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 5'd1}; // edge N: accepted
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 5'd0}; // N+1: strobe up
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 5'd0}; // N+2: held
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 5'd0}; // N+3: gap
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 5'd0}; // N+4: gap
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 5'd0}; // N+5: idle
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 5'd0};
        base = cap_ch.size();
        for (int i = 0; i < 7; i++) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
            step();
            chk($sformatf("single_vec%0d", i), {strobe, char, busy, level, wr_ready},
                {vecs[i].exp_strobe, vecs[i].exp_char, vecs[i].exp_busy, vecs[i].exp_level, 1'b1});
        end
        chk("single_count", cap_ch.size() - base, 1);
        if (cap_ch.size() > base) chk("single_char", {24'd0, cap_ch[base]}, 32'h41);

        // ---- burst of 24 writes: fill, overflow, write-vs-pop on full ----
        // pops land on burst edges 2,7,12,17,22; full after edge 20;
        // 0x14 (edge 21, with clr), 0x15 (edge 22, pop edge) and 0x17 dropped
        base = cap_ch.size();
        for (int k = 1; k <= 24; k++) begin
            wr_en = 1'b1; wr_data = 8'(k - 1);
            clr_overflow = (k == 21);
            step();
            if (k == 19) chk("burst_ready19", {31'd0, wr_ready}, 32'd1);
            if (k == 20) chk("burst_full", {level, wr_ready, overflow}, {5'd16, 1'b0, 1'b0});
            if (k == 21) chk("ovf_set_beats_clr", {level, overflow}, {5'd16, 1'b1});
            if (k == 22) chk("full_write_on_pop", {level, overflow}, {5'd15, 1'b1});
            if (k == 23) chk("refill_after_pop", {27'd0, level}, 32'd16);
        end
        wr_en = 1'b0; clr_overflow = 1'b0;
        wait_idle();
        for (int v = 0; v <= 8'h13; v++) exp_list.push_back(8'(v));
        exp_list.push_back(8'h16);
        chk("burst_count", cap_ch.size() - base, exp_list.size());
        for (int i = 0; i < exp_list.size() && base + i < cap_ch.size(); i++)
            chk($sformatf("burst_byte%0d", i), {24'd0, cap_ch[base+i]}, {24'd0, exp_list[i]});
        chk("ovf_still_set", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_clr_alone", {31'd0, overflow}, 32'd0);

        // ---- "Hi\n" back-to-back: rising strobes 5 cycles apart ----
        base = cap_ch.size();
        wr_en = 1'b1; wr_data = 8'h48; step();
        wr_data = 8'h69; step();
        wr_data = 8'h0A; step();
        wr_en = 1'b0;
        wait_idle();
        chk("hi_count", cap_ch.size() - base, 3);
        if (cap_ch.size() >= base + 3) begin
            chk("hi_c0", {24'd0, cap_ch[base]},   32'h48);
            chk("hi_c1", {24'd0, cap_ch[base+1]}, 32'h69);
            chk("hi_c2", {24'd0, cap_ch[base+2]}, 32'h0A);
            chk("hi_gap01", cap_cyc[base+1] - cap_cyc[base],   5);
            chk("hi_gap12", cap_cyc[base+2] - cap_cyc[base+1], 5);
        end

        // ---- reset in the middle of a pulse ----
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin wr_data = 8'h30 + 8'(i); step(); end
        wr_en = 1'b0;
        chk("pre_reset_strobe", {31'd0, strobe}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset", {char, strobe, overflow, level, wr_ready, busy},
               {8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        base = cap_ch.size();
        repeat (10) step();
        chk("post_reset_quiet", {level, strobe, busy}, {5'd0, 1'b0, 1'b0});
        chk("post_reset_no_strobe", cap_ch.size() - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
